// File: rtl/bit_deserializer_if.sv
// Serial bit input and parallel word output bundle for bit_deserializer.
// The master side drives the serial stream; the slave side is the deserializer.
interface bit_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             data_i;
  logic             data_val_i;
  logic [WIDTH-1:0] data_o;
  logic             data_val_o;
  logic             busy_o;
  logic             drop_o;

  modport master (
    output data_i, data_val_i,
    input  data_o, data_val_o, busy_o, drop_o
  );

  modport slave (
    input  data_i, data_val_i,
    output data_o, data_val_o, busy_o, drop_o
  );
endinterface

// File: rtl/bit_deserializer.sv
// Packs qualified serial bits into WIDTH-bit words with a one-cycle valid strobe.
// Partial words are discarded after TIMEOUT idle cycles and reported on drop_o.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  bit_deserializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_nxt, data_q;
  logic             val_q, drop_q;
  logic             word_done, drop_d, gap_hit;

  // Completed word is taken from sh_nxt so it already includes the current bit.
  always_comb begin
    if (MSB_FIRST != 0) sh_nxt = {sh_q[WIDTH-2:0], bus.data_i};
    else                sh_nxt = {bus.data_i, sh_q[WIDTH-1:1]};
  end

  generate
    if (TIMEOUT > 0) begin : g_gap
      localparam int GW = $clog2(TIMEOUT + 1);
      logic [GW-1:0] gap_q;

      assign gap_hit = (state_q == COLLECT) && !bus.data_val_i &&
                       (gap_q == GW'(TIMEOUT - 1));

      always_ff @(posedge clk_i) begin
        if (srst_i || bus.data_val_i || state_q != COLLECT || gap_hit)
          gap_q <= '0;
        else if (gap_q != GW'(TIMEOUT))
          gap_q <= gap_q + GW'(1);
      end
    end else begin : g_nogap
      assign gap_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    drop_d    = 1'b0;
    if (bus.data_val_i) begin
      if (cnt_q == CW'(WIDTH - 1)) begin
        word_done = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        state_d = COLLECT;
      end
    end else if (gap_hit) begin
      drop_d  = 1'b1;
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.data_val_i) sh_q   <= sh_nxt;
      if (word_done)      data_q <= sh_nxt;
      val_q  <= word_done;
      drop_q <= drop_d;
    end
  end

  assign bus.data_o     = data_q;
  assign bus.data_val_o = val_q;
  assign bus.drop_o     = drop_q;
  assign bus.busy_o     = (state_q == COLLECT);
endmodule

// File: tb/tb_bit_deserializer.sv
// Directed and random checks of bit_deserializer in three configurations
// sharing one stimulus stream: MSB-first/T16, LSB-first/T16, MSB-first/T4.
module tb_bit_deserializer;
  logic clk = 1'b0;
  logic srst, din, dval;
  int   n_chk = 0, n_fail = 0;
  logic [7:0] p0, p1;

  always #5 clk = ~clk;

  bit_deserializer_if #(.WIDTH(8)) if0 (), if1 (), if2 ();

  assign if0.data_i = din;  assign if0.data_val_i = dval;
  assign if1.data_i = din;  assign if1.data_val_i = dval;
  assign if2.data_i = din;  assign if2.data_val_i = dval;

  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(16)) u0 (.clk_i(clk), .srst_i(srst), .bus(if0));
  bit_deserializer #(.WIDTH(8), .MSB_FIRST(0), .TIMEOUT(16)) u1 (.clk_i(clk), .srst_i(srst), .bus(if1));
  bit_deserializer #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(4))  u2 (.clk_i(clk), .srst_i(srst), .bus(if2));

  logic [7:0] o_data [3];
  logic       o_val  [3];
  logic       o_drop [3];
  logic       o_busy [3];
  assign o_data[0] = if0.data_o;  assign o_val[0] = if0.data_val_o;
  assign o_drop[0] = if0.drop_o;  assign o_busy[0] = if0.busy_o;
  assign o_data[1] = if1.data_o;  assign o_val[1] = if1.data_val_o;
  assign o_drop[1] = if1.drop_o;  assign o_busy[1] = if1.busy_o;
  assign o_data[2] = if2.data_o;  assign o_val[2] = if2.data_val_o;
  assign o_drop[2] = if2.drop_o;  assign o_busy[2] = if2.busy_o;

  // Reference model state for the random phase
  int         MSF [3] = '{1, 0, 1};
  int         TOV [3] = '{16, 16, 4};
  int         m_cnt [3];
  int         m_gap [3];
  logic [7:0] m_bits [3];
  logic [7:0] m_data [3];
  logic       m_val [3];
  logic       m_drop [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic b, input logic r);
    srst = r; dval = v; din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic v, input logic dr, input logic bz);
    chk({tag, "/u0"}, {o_data[0], o_val[0], o_drop[0], o_busy[0]}, {e0, v, dr, bz});
    chk({tag, "/u1"}, {o_data[1], o_val[1], o_drop[1], o_busy[1]}, {e1, v, dr, bz});
    chk({tag, "/u2"}, {o_data[2], o_val[2], o_drop[2], o_busy[2]}, {e2, v, dr, bz});
  endtask

  // Sends w MSB first; optional 3 idle cycles after bit index gap_at.
  task automatic send_word(input logic [7:0] w, input int gap_at,
                           input logic [7:0] x0, input logic [7:0] x1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, w[7-i], 1'b0);
      if (i < 7) chk3("word_mid", p0, p1, p0, 1'b0, 1'b0, 1'b1);
      else begin
        chk3("word_end", x0, x1, x0, 1'b1, 1'b0, 1'b0);
        p0 = x0; p1 = x1;
      end
      if (i == gap_at)
        repeat (3) begin
          cyc(1'b0, 1'b0, 1'b0);
          chk3("word_gap", p0, p1, p0, 1'b0, 1'b0, 1'b1);
        end
    end
  endtask

  task automatic model_step(input int k, input logic v, input logic b, input logic r);
    m_val[k]  = 1'b0;
    m_drop[k] = 1'b0;
    if (r) begin
      m_cnt[k] = 0; m_gap[k] = 0; m_data[k] = 8'h00;
    end else if (v) begin
      m_bits[k][m_cnt[k]] = b;
      m_cnt[k]++;
      m_gap[k] = 0;
      if (m_cnt[k] == 8) begin
        for (int i = 0; i < 8; i++)
          if (MSF[k] != 0) m_data[k][7-i] = m_bits[k][i];
          else             m_data[k][i]   = m_bits[k][i];
        m_val[k] = 1'b1;
        m_cnt[k] = 0;
      end
    end else if (m_cnt[k] > 0 && TOV[k] > 0) begin
      m_gap[k]++;
      if (m_gap[k] == TOV[k]) begin
        m_drop[k] = 1'b1; m_cnt[k] = 0; m_gap[k] = 0;
      end
    end
  endtask

  initial begin
    logic       r, v, b;
    int         dens;
    logic [4:0] to_bits;
    srst = 1'b1; dval = 1'b0; din = 1'b0;
    p0 = 8'h00; p1 = 8'h00;
    dens = 100;

    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk3("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (20) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk3("idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    send_word(8'hB2, -1, 8'hB2, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0);
    chk3("hold", p0, p1, p0, 1'b0, 1'b0, 1'b0);

    send_word(8'hFF, -1, 8'hFF, 8'hFF);
    send_word(8'h00, -1, 8'h00, 8'h00);
    send_word(8'hA5, -1, 8'hA5, 8'hA5);
    send_word(8'hFF, 3, 8'hFF, 8'hFF);
    send_word(8'h00, 3, 8'h00, 8'h00);
    send_word(8'hA5, 3, 8'hA5, 8'hA5);

    // Timeout: 5 bits then 4 idle cycles drops only on the TIMEOUT=4 instance
    to_bits = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, to_bits[4-i], 1'b0);
      chk3("to_bits", p0, p1, p0, 1'b0, 1'b0, 1'b1);
    end
    for (int j = 1; j <= 4; j++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (j < 4) chk3("to_wait", p0, p1, p0, 1'b0, 1'b0, 1'b1);
      else begin
        chk("to_drop_u2", {o_data[2], o_val[2], o_drop[2], o_busy[2]}, {8'hA5, 1'b0, 1'b1, 1'b0});
        chk("to_held_u0", {o_drop[0], o_busy[0]}, 2'b01);
      end
    end
    cyc(1'b0, 1'b0, 1'b0);
    chk("to_after_u2", {o_data[2], o_val[2], o_drop[2], o_busy[2]}, {8'hA5, 1'b0, 1'b0, 1'b0});
    cyc(1'b0, 1'b0, 1'b1);
    chk3("to_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    p0 = 8'h00; p1 = 8'h00;

    // Bit arriving on the 4th idle cycle rescues the word
    send_word(8'hCA, 4, 8'hCA, 8'h53);

    // Reset mid-word with a valid bit present
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      chk3("rst_bits", p0, p1, p0, 1'b0, 1'b0, 1'b1);
    end
    cyc(1'b1, 1'b1, 1'b1);
    chk3("rst_mid", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    p0 = 8'h00; p1 = 8'h00;
    send_word(8'h3C, -1, 8'h3C, 8'h3C);

    // Random soak against the reference model
    for (int c = 0; c < 10000; c++) begin
      if (c % 200 == 0) dens = int'($urandom_range(10, 100));
      r = (c == 0) || ($urandom_range(0, 299) == 0);
      v = (int'($urandom_range(1, 100)) <= dens);
      b = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++) model_step(k, v, b, r);
      cyc(v, b, r);
      for (int k = 0; k < 3; k++) begin
        chk("soak_val",  {31'd0, o_val[k]},  {31'd0, m_val[k]});
        chk("soak_drop", {31'd0, o_drop[k]}, {31'd0, m_drop[k]});
        chk("soak_busy", {31'd0, o_busy[k]}, {31'd0, 1'(m_cnt[k] > 0)});
        chk("soak_data", {24'd0, o_data[k]}, {24'd0, m_data[k]});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
